// File: rtl/usb_pkg.sv
// Shared USB constants: standard/class descriptor type codes and the
// descriptor-sender FSM state encoding.
package usb_pkg;

  localparam logic [7:0] DT_DEVICE      = 8'h01;
  localparam logic [7:0] DT_CONFIG      = 8'h02;
  localparam logic [7:0] DT_STRING      = 8'h03;
  localparam logic [7:0] DT_QUALIFIER   = 8'h06;
  localparam logic [7:0] DT_OTHER_SPEED = 8'h07;
  localparam logic [7:0] DT_BOS         = 8'h0F;
  localparam logic [7:0] DT_HID_REPORT  = 8'h22;

  // String descriptor 0 (LANGID list) has a fixed size
  localparam logic [15:0] STRLANG_LEN = 16'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_SEND,
    ST_WAIT_ACK,
    ST_ZLP,
    ST_WAIT_ZACK
  } desc_state_t;

endpackage

// File: rtl/usb_desc_sel.sv
// Combinational descriptor lookup: maps (type, index, speed) onto a ROM base
// address and length, and flags requests that must be stalled.
module usb_desc_sel
  import usb_pkg::*;
(
  input  logic [7:0]  req_type,
  input  logic [7:0]  req_index,
  input  logic        req_hs,
  input  logic        desc_have_strings_i,
  input  logic [15:0] desc_dev_addr_i,
  input  logic [15:0] desc_dev_len_i,
  input  logic [15:0] desc_fscfg_addr_i,
  input  logic [15:0] desc_fscfg_len_i,
  input  logic [15:0] desc_hscfg_addr_i,
  input  logic [15:0] desc_hscfg_len_i,
  input  logic [15:0] desc_strlang_addr_i,
  input  logic [15:0] desc_vendor_addr_i,
  input  logic [15:0] desc_vendor_len_i,
  input  logic [15:0] desc_product_addr_i,
  input  logic [15:0] desc_product_len_i,
  input  logic [15:0] desc_serial_addr_i,
  input  logic [15:0] desc_serial_len_i,
  input  logic [15:0] desc_qual_addr_i,
  input  logic [15:0] desc_qual_len_i,
  input  logic [15:0] desc_oscfg_addr_i,
  input  logic [15:0] desc_bos_addr_i,
  input  logic [15:0] desc_bos_len_i,
  input  logic [15:0] desc_hidrpt_addr_i,
  input  logic [15:0] desc_hidrpt_len_i,
  output logic [15:0] base,
  output logic [15:0] len,
  output logic        stall
);

  logic known;

  always_comb begin
    base  = '0;
    len   = '0;
    known = 1'b1;
    unique case (req_type)
      DT_DEVICE: begin
        base = desc_dev_addr_i;
        len  = desc_dev_len_i;
      end
      DT_CONFIG: begin
        base = req_hs ? desc_hscfg_addr_i : desc_fscfg_addr_i;
        len  = req_hs ? desc_hscfg_len_i  : desc_fscfg_len_i;
      end
      DT_STRING: begin
        unique case (req_index)
          8'd0: begin
            base = desc_strlang_addr_i;
            len  = STRLANG_LEN;
          end
          8'd1: begin
            base = desc_vendor_addr_i;
            len  = desc_vendor_len_i;
          end
          8'd2: begin
            base = desc_product_addr_i;
            len  = desc_product_len_i;
          end
          8'd3: begin
            base = desc_serial_addr_i;
            len  = desc_serial_len_i;
          end
          default: known = 1'b0;
        endcase
      end
      DT_QUALIFIER: begin
        base = desc_qual_addr_i;
        len  = desc_qual_len_i;
      end
      // Other-speed config reuses the opposite speed's config length
      DT_OTHER_SPEED: begin
        base = desc_oscfg_addr_i;
        len  = req_hs ? desc_fscfg_len_i : desc_hscfg_len_i;
      end
      DT_BOS: begin
        base = desc_bos_addr_i;
        len  = desc_bos_len_i;
      end
      DT_HID_REPORT: begin
        base = desc_hidrpt_addr_i;
        len  = desc_hidrpt_len_i;
      end
      default: known = 1'b0;
    endcase
  end

  assign stall = !known
              || ((req_type == DT_STRING) && !desc_have_strings_i)
              || (len == '0);

endmodule

// File: rtl/usb_desc_sender.sv
// EP0 GET_DESCRIPTOR data-stage engine: streams a ROM-resident descriptor in
// MAXPKT-sized packets with ACK/retry handling and a trailing ZLP when needed.
module usb_desc_sender
  import usb_pkg::*;
#(
  parameter int unsigned MAXPKT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [7:0]  req_type,
  input  logic [7:0]  req_index,
  input  logic [15:0] req_length,
  input  logic        req_hs,
  input  logic        abort,
  input  logic [15:0] desc_dev_addr_i,
  input  logic [15:0] desc_dev_len_i,
  input  logic [15:0] desc_fscfg_addr_i,
  input  logic [15:0] desc_fscfg_len_i,
  input  logic [15:0] desc_hscfg_addr_i,
  input  logic [15:0] desc_hscfg_len_i,
  input  logic [15:0] desc_strlang_addr_i,
  input  logic [15:0] desc_vendor_addr_i,
  input  logic [15:0] desc_vendor_len_i,
  input  logic [15:0] desc_product_addr_i,
  input  logic [15:0] desc_product_len_i,
  input  logic [15:0] desc_serial_addr_i,
  input  logic [15:0] desc_serial_len_i,
  input  logic [15:0] desc_qual_addr_i,
  input  logic [15:0] desc_qual_len_i,
  input  logic [15:0] desc_oscfg_addr_i,
  input  logic [15:0] desc_bos_addr_i,
  input  logic [15:0] desc_bos_len_i,
  input  logic [15:0] desc_hidrpt_addr_i,
  input  logic [15:0] desc_hidrpt_len_i,
  input  logic        desc_have_strings_i,
  output logic [15:0] descrom_raddr_o,
  input  logic [7:0]  descrom_rdata_i,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        tx_zlp,
  input  logic        pkt_ack,
  input  logic        pkt_retry,
  output logic        req_stall,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] PKT_M1 = 16'(MAXPKT - 1);

  desc_state_t state, next_state;

  logic [7:0]  type_q, index_q;
  logic        hs_q;
  logic [15:0] length_q;
  logic [15:0] ptr, pkt_start, xlen, base;
  logic        oscfg_q, stall_q, done_q;

  logic [15:0] sel_base, sel_len, xlen_next;
  logic        sel_stall, fire, last_byte, bytes_left, need_zlp, finish;

  usb_desc_sel u_sel (
    .req_type            (type_q),
    .req_index           (index_q),
    .req_hs              (hs_q),
    .desc_have_strings_i (desc_have_strings_i),
    .desc_dev_addr_i     (desc_dev_addr_i),
    .desc_dev_len_i      (desc_dev_len_i),
    .desc_fscfg_addr_i   (desc_fscfg_addr_i),
    .desc_fscfg_len_i    (desc_fscfg_len_i),
    .desc_hscfg_addr_i   (desc_hscfg_addr_i),
    .desc_hscfg_len_i    (desc_hscfg_len_i),
    .desc_strlang_addr_i (desc_strlang_addr_i),
    .desc_vendor_addr_i  (desc_vendor_addr_i),
    .desc_vendor_len_i   (desc_vendor_len_i),
    .desc_product_addr_i (desc_product_addr_i),
    .desc_product_len_i  (desc_product_len_i),
    .desc_serial_addr_i  (desc_serial_addr_i),
    .desc_serial_len_i   (desc_serial_len_i),
    .desc_qual_addr_i    (desc_qual_addr_i),
    .desc_qual_len_i     (desc_qual_len_i),
    .desc_oscfg_addr_i   (desc_oscfg_addr_i),
    .desc_bos_addr_i     (desc_bos_addr_i),
    .desc_bos_len_i      (desc_bos_len_i),
    .desc_hidrpt_addr_i  (desc_hidrpt_addr_i),
    .desc_hidrpt_len_i   (desc_hidrpt_len_i),
    .base                (sel_base),
    .len                 (sel_len),
    .stall               (sel_stall)
  );

  assign xlen_next  = (sel_len < length_q) ? sel_len : length_q;
  assign fire       = tx_valid && tx_ready;
  // 17-bit compare so a packet end near 16'hFFFF cannot wrap into a false match
  assign last_byte  = ({1'b0, ptr} == ({1'b0, pkt_start} + {1'b0, PKT_M1}))
                   || (ptr == (xlen - 16'd1));
  assign bytes_left = (ptr != xlen);
  assign need_zlp   = (xlen < length_q) && ((xlen & PKT_M1) == '0);
  assign finish     = ((state == ST_WAIT_ACK) && pkt_ack && !pkt_retry && !bytes_left && !need_zlp)
                   || ((state == ST_WAIT_ZACK) && pkt_ack && !pkt_retry);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:      if (req_valid) next_state = ST_LOOKUP;
        ST_LOOKUP: begin
          if (sel_stall)            next_state = ST_IDLE;
          else if (length_q == '0)  next_state = ST_ZLP;
          else                      next_state = ST_SEND;
        end
        ST_SEND:      if (fire && last_byte) next_state = ST_WAIT_ACK;
        ST_WAIT_ACK: begin
          if (pkt_retry)                   next_state = ST_SEND;
          else if (pkt_ack && bytes_left)  next_state = ST_SEND;
          else if (pkt_ack && need_zlp)    next_state = ST_ZLP;
          else if (pkt_ack)                next_state = ST_IDLE;
        end
        ST_ZLP:       next_state = ST_WAIT_ZACK;
        ST_WAIT_ZACK: begin
          if (pkt_retry)     next_state = ST_ZLP;
          else if (pkt_ack)  next_state = ST_IDLE;
        end
        default:      next_state = ST_IDLE;
      endcase
    end
  end

  // Abort clears the datapath exactly like reset so both leave the same state
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      type_q    <= '0;
      index_q   <= '0;
      hs_q      <= 1'b0;
      length_q  <= '0;
      ptr       <= '0;
      pkt_start <= '0;
      xlen      <= '0;
      base      <= '0;
      oscfg_q   <= 1'b0;
      stall_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      stall_q <= (state == ST_LOOKUP) && sel_stall;
      done_q  <= finish;
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            type_q   <= req_type;
            index_q  <= req_index;
            hs_q     <= req_hs;
            length_q <= req_length;
          end
        end
        ST_LOOKUP: begin
          base      <= sel_base;
          xlen      <= xlen_next;
          ptr       <= '0;
          pkt_start <= '0;
          oscfg_q   <= (type_q == DT_OTHER_SPEED);
        end
        ST_SEND: begin
          if (fire) ptr <= ptr + 16'd1;
        end
        ST_WAIT_ACK: begin
          if (pkt_retry)                  ptr       <= pkt_start;
          else if (pkt_ack && bytes_left) pkt_start <= ptr;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_valid        = 1'b0;
    tx_last         = 1'b0;
    tx_zlp          = 1'b0;
    tx_data         = '0;
    busy            = 1'b0;
    req_stall       = 1'b0;
    done            = 1'b0;
    descrom_raddr_o = '0;
    if (!rst) begin
      descrom_raddr_o = base + ptr;
      busy            = (state != ST_IDLE);
      req_stall       = stall_q;
      done            = done_q;
      unique case (state)
        ST_SEND: begin
          tx_valid = 1'b1;
          tx_last  = last_byte;
          tx_data  = (oscfg_q && (ptr == 16'd1)) ? 8'h07 : descrom_rdata_i;
        end
        ST_ZLP:  tx_zlp = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
